// File: rtl/sa2_tile_sequencer_if.sv
// Tile sequencer bundle: load stream, array control/results, result stream, status.
// master = sequencer side, slave = environment side.
interface sa2_tile_sequencer_if;
  logic         start;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] a_mat;
  logic [71:0]  b_mat;
  logic         active_sa2;
  logic         done_sa2;
  logic [7:0]   c11;
  logic [7:0]   c12;
  logic [7:0]   c21;
  logic [7:0]   c22;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         err;

  modport master (
    input  start, in_valid, in_data,
    input  done_sa2, c11, c12, c21, c22,
    input  out_ready,
    output in_ready, a_mat, b_mat, active_sa2,
    output out_valid, out_data, out_last,
    output busy, done, err
  );

  modport slave (
    output start, in_valid, in_data,
    output done_sa2, c11, c12, c21, c22,
    output out_ready,
    input  in_ready, a_mat, b_mat, active_sa2,
    input  out_valid, out_data, out_last,
    input  busy, done, err
  );
endinterface

// File: rtl/sa2_tile_sequencer.sv
// Sequences one 4x4 tile + 3x3 filter into the 2x2 array and
// streams the four results back out, with a RUN-phase timeout.
module sa2_tile_sequencer #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  sa2_tile_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    OUT
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [4:0] ld_cnt;
  logic [7:0] wait_cnt;
  logic [1:0] beat;
  logic [7:0] res [4];
  logic       xfer;
  logic [1:0] beat_nx;
  logic [6:0] ld_sel;

  assign xfer    = bus.in_valid & bus.in_ready;
  assign beat_nx = beat + 2'd1;
  // beats 16..24 wrap onto b bytes 0..8 through the low nibble
  assign ld_sel  = {ld_cnt[3:0], 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      ld_cnt         <= '0;
      wait_cnt       <= '0;
      beat           <= '0;
      for (int i = 0; i < 4; i++)
        res[i] <= '0;
      bus.in_ready   <= 1'b0;
      bus.a_mat      <= '0;
      bus.b_mat      <= '0;
      bus.active_sa2 <= 1'b0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= LOAD;
            ld_cnt       <= '0;
            bus.err      <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end
        end
        LOAD: begin
          if (xfer) begin
            if (ld_cnt < 5'd16)
              bus.a_mat[ld_sel +: 8] <= bus.in_data;
            else
              bus.b_mat[ld_sel +: 8] <= bus.in_data;
            if (ld_cnt == 5'd24) begin
              state          <= RUN;
              wait_cnt       <= '0;
              bus.in_ready   <= 1'b0;
              bus.active_sa2 <= 1'b1;
            end else begin
              ld_cnt <= ld_cnt + 5'd1;
            end
          end
        end
        RUN: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (bus.done_sa2) begin
            state          <= OUT;
            res[0]         <= bus.c11;
            res[1]         <= bus.c12;
            res[2]         <= bus.c21;
            res[3]         <= bus.c22;
            beat           <= '0;
            bus.active_sa2 <= 1'b0;
            bus.out_valid  <= 1'b1;
            bus.out_data   <= bus.c11;
            bus.out_last   <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state          <= IDLE;
            bus.active_sa2 <= 1'b0;
            bus.busy       <= 1'b0;
            bus.err        <= 1'b1;
          end
        end
        OUT: begin
          if (bus.out_ready) begin
            if (beat == 2'd3) begin
              state         <= IDLE;
              beat          <= '0;
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
              bus.out_data  <= '0;
              bus.busy      <= 1'b0;
              bus.done      <= 1'b1;
            end else begin
              beat         <= beat_nx;
              bus.out_data <= res[beat_nx];
              bus.out_last <= (beat_nx == 2'd3);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa2_tile_sequencer.sv
// Randomized bench for sa2_tile_sequencer against a tile-level
// reference model (byte arrays in, result queue out).
module tb_sa2_tile_sequencer;

  logic clk = 1'b0;
  logic rst;

  sa2_tile_sequencer_if sif ();

  sa2_tile_sequencer #(.TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_a"}, sif.a_mat, '0);
    chk({tag, "_b"}, {56'd0, sif.b_mat}, '0);
    chk({tag, "_ctl"},
        {sif.in_ready, sif.active_sa2, sif.out_valid,
         sif.out_last, sif.busy, sif.done, sif.err}, '0);
    chk({tag, "_od"}, sif.out_data, '0);
  endtask

  // pat 0: bytes 1..25, results 11/22/33/44; else random
  // gap 0: in_valid always, 1: alternate, 2: random
  // done_at: RUN cycle (1-based) of done_sa2, 0 = never
  // rmode 0: out_ready=1, 1: 1-0-0-1 pattern, 2: random
  task automatic run_tile(input int pat, input int gap,
                          input int done_at, input int rmode);
    logic [7:0]   bytes [25];
    logic [7:0]   cv [4];
    logic [127:0] ea;
    logic [71:0]  eb;
    int           n;
    int           cyc;
    int           idx;
    bit           fire;
    ea = '0;
    eb = '0;
    for (int i = 0; i < 25; i++) begin
      bytes[i] = (pat == 0) ? 8'(i + 1) : 8'($urandom);
      if (i < 16) ea[8*i +: 8] = bytes[i];
      else        eb[8*(i-16) +: 8] = bytes[i];
    end
    for (int i = 0; i < 4; i++)
      cv[i] = (pat == 0) ? 8'(8'h11 * (i + 1)) : 8'($urandom);

    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    chk("start_ready", sif.in_ready, 1);
    chk("start_busy", sif.busy, 1);
    chk("start_err_clr", sif.err, 0);

    n = 0;
    cyc = 0;
    while (n < 25 && cyc < 400) begin
      if (gap == 0)      sif.in_valid = 1'b1;
      else if (gap == 1) sif.in_valid = (cyc % 2 == 0);
      else               sif.in_valid = ($urandom % 3 != 0);
      sif.in_data = bytes[n];
      fire = sif.in_valid && sif.in_ready;
      tick();
      cyc++;
      if (fire) n++;
      if (fire && n == 24) chk("load_not_run", sif.active_sa2, 0);
    end
    sif.in_valid = 1'b0;
    sif.in_data  = '0;
    chk("load_count", n, 25);
    if (n != 25) return;
    chk("run_active", sif.active_sa2, 1);
    chk("run_ready_low", sif.in_ready, 0);
    chk("a_mat", sif.a_mat, ea);
    chk("b_mat", {56'd0, sif.b_mat}, {56'd0, eb});

    fire = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      sif.start = $urandom_range(0, 1);
      fire = (k == done_at);
      sif.done_sa2 = fire;
      if (fire) begin
        sif.c11 = cv[0];
        sif.c12 = cv[1];
        sif.c21 = cv[2];
        sif.c22 = cv[3];
      end
      if (fire || k == 64) chk("run_hold", sif.active_sa2, 1);
      tick();
      sif.done_sa2 = 1'b0;
      sif.c11 = 8'($urandom);
      sif.c12 = 8'($urandom);
      sif.c21 = 8'($urandom);
      sif.c22 = 8'($urandom);
      if (fire) break;
    end
    sif.start = 1'b0;
    chk("a_hold", sif.a_mat, ea);

    if (!fire) begin
      chk("to_err", sif.err, 1);
      chk("to_active", sif.active_sa2, 0);
      chk("to_busy", sif.busy, 0);
      chk("to_valid", sif.out_valid, 0);
      tick();
      chk("to_no_done", sif.done, 0);
      chk("to_err_sticky", sif.err, 1);
      return;
    end

    chk("out_inactive", sif.active_sa2, 0);
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 200) begin
      if (rmode == 0)      sif.out_ready = 1'b1;
      else if (rmode == 1) sif.out_ready = (cyc % 4 == 0 || cyc % 4 == 3);
      else                 sif.out_ready = $urandom_range(0, 1);
      chk("out_valid", sif.out_valid, 1);
      chk("out_data", sif.out_data, cv[idx]);
      chk("out_last", sif.out_last, (idx == 3));
      chk("out_done_low", sif.done, 0);
      fire = sif.out_valid && sif.out_ready;
      tick();
      cyc++;
      if (fire) idx++;
    end
    sif.out_ready = 1'b0;
    chk("out_count", idx, 4);
    if (idx != 4) return;
    chk("done_pulse", sif.done, 1);
    chk("done_busy", sif.busy, 0);
    chk("done_valid", sif.out_valid, 0);
    tick();
    chk("done_single", sif.done, 0);
    chk("idle_busy", sif.busy, 0);
  endtask

  initial begin
    rst           = 1'b0;
    sif.start     = 1'b0;
    sif.in_valid  = 1'b0;
    sif.in_data   = '0;
    sif.done_sa2  = 1'b0;
    sif.c11       = '0;
    sif.c12       = '0;
    sif.c21       = '0;
    sif.c22       = '0;
    sif.out_ready = 1'b0;
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b1;
    tick();

    sif.done_sa2 = 1'b1;
    tick();
    tick();
    sif.done_sa2 = 1'b0;
    chk("idle_done_ign",
        {sif.busy, sif.out_valid, sif.active_sa2}, '0);

    run_tile(0, 0, 29, 0);
    run_tile(0, 1, 29, 1);
    run_tile(1, 2, 0, 2);
    run_tile(1, 2, 17, 2);

    sif.start = 1'b1;
    tick();
    sif.start = 1'b0;
    sif.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      sif.in_data = 8'($urandom | 1);
      tick();
    end
    sif.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_idle_zero("midload_rst");
    @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    chk("post_rst_busy", sif.busy, 0);
    run_tile(0, 0, 29, 0);

    for (int t = 0; t < 8; t++)
      run_tile(1, 2,
               ($urandom % 6 == 0) ? 0 : $urandom_range(1, 63),
               2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
